// File: rtl/task_graph_streamer.sv
// task_graph_streamer: holds one NUM_V x NUM_V task-graph adjacency matrix and
// replays it row-major, cell by cell, NUM_APPS times toward task_mapper.
// Optional build macro: SKIP_ZERO_EN -- zero-weight cells take a single
// invalid cycle instead of being emitted with the full hold/handshake.
//
// state | meaning
// IDLE  | waiting for start; matrix writable
// EMIT  | current cell on the outputs, held HOLD_CYC+ cycles until map_ready
// SKIP  | zero cell passed over in one cycle (SKIP_ZERO_EN builds only)
// END   | app_end pulse, app_cnt increments
// GAP   | one idle cycle; restart next application or finish with done
module task_graph_streamer #(
    parameter int NUM_V    = 4,
    parameter int W        = 32,
    parameter int HOLD_CYC = 2,
    parameter int AW       = $clog2(NUM_V),
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_row,
    input  logic [AW-1:0] wr_col,
    input  logic [W-1:0]  wr_data,
    input  logic [CW-1:0] num_apps,
    input  logic          start,
    input  logic          map_ready,
    output logic          task_valid,
    output logic [W-1:0]  task_array,
    output logic [AW-1:0] row,
    output logic [AW-1:0] col,
    output logic          root_task,
    output logic          app_end,
    output logic          busy,
    output logic [CW-1:0] app_cnt,
    output logic          done
);

    localparam int NCELL = NUM_V * NUM_V;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int HW    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);
    localparam logic [AW-1:0] IDX_MAX  = AW'(NUM_V - 1);

`ifdef SKIP_ZERO_EN
    typedef enum logic [2:0] {S_IDLE, S_EMIT, S_SKIP, S_END, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_EMIT, S_END, S_GAP} state_t;
`endif

    state_t          state_q, state_d;
    logic [AW-1:0]   row_q, row_d, col_q, col_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            seen_q, seen_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   lat_q, lat_d;
    logic            zdone_q, zdone_d;

    logic [W-1:0]    mem [NCELL];
    logic [IW-1:0]   wr_idx, cur_idx;
    logic [W-1:0]    cur_w;

    logic            col_wrap, last_cell, adv;
    logic [AW-1:0]   nxt_row, nxt_col;
    state_t          nxt_cell_st, first_cell_st;

    assign wr_idx  = IW'(wr_row) * IW'(NUM_V) + IW'(wr_col);
    assign cur_idx = IW'(row_q) * IW'(NUM_V) + IW'(col_q);
    assign cur_w   = mem[cur_idx];

    // Matrix storage: writable only while idle, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCELL; i++) mem[i] <= '0;
        end else if (wr_en && state_q == S_IDLE) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Row-major successor of the current cell and the state it should enter.
    always_comb begin
        col_wrap  = (col_q == IDX_MAX);
        last_cell = col_wrap && (row_q == IDX_MAX);
        nxt_col   = col_wrap ? '0 : col_q + 1'b1;
        nxt_row   = col_wrap ? row_q + 1'b1 : row_q;
`ifdef SKIP_ZERO_EN
        nxt_cell_st   = (mem[IW'(nxt_row) * IW'(NUM_V) + IW'(nxt_col)] == '0) ? S_SKIP : S_EMIT;
        first_cell_st = (mem[0] == '0) ? S_SKIP : S_EMIT;
`else
        nxt_cell_st   = S_EMIT;
        first_cell_st = S_EMIT;
`endif
    end

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            hold_q  <= '0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            lat_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hold_q  <= hold_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            zdone_q <= zdone_d;
        end
    end

    // Next-state logic: hold/handshake, cell advance, application sequencing.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        hold_d  = hold_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        zdone_d = 1'b0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_apps != '0) begin
                        lat_d   = num_apps;
                        cnt_d   = '0;
                        seen_d  = 1'b0;
                        row_d   = '0;
                        col_d   = '0;
                        hold_d  = '0;
                        state_d = first_cell_st;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end else if (map_ready) begin
                    if (cur_w != '0) seen_d = 1'b1;
                    adv = 1'b1;
                end
            end
`ifdef SKIP_ZERO_EN
            S_SKIP: adv = 1'b1;
`endif
            S_END: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q < lat_q) begin
                    seen_d  = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    hold_d  = '0;
                    state_d = first_cell_st;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            hold_d = '0;
            if (last_cell) begin
                row_d   = '0;
                col_d   = '0;
                state_d = S_END;
            end else begin
                row_d   = nxt_row;
                col_d   = nxt_col;
                state_d = nxt_cell_st;
            end
        end
    end

    // Outputs decoded from registered state; task_array is zeroed when not valid.
    assign task_valid = (state_q == S_EMIT);
    assign task_array = task_valid ? cur_w : '0;
    assign row        = row_q;
    assign col        = col_q;
    assign root_task  = task_valid && (cur_w != '0) && !seen_q;
    assign app_end    = (state_q == S_END);
    assign busy       = (state_q != S_IDLE);
    assign app_cnt    = cnt_q;
    assign done       = zdone_q || ((state_q == S_GAP) && !(cnt_q < lat_q));

endmodule

// File: tb/tb_task_graph_streamer.sv
// Directed bench for task_graph_streamer (NUM_V=4, W=32, HOLD_CYC=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_task_graph_streamer;
    localparam int NUM_V = 4;
    localparam int W     = 32;
    localparam int AW    = 2;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_row = '0;
    logic [AW-1:0] wr_col = '0;
    logic [W-1:0]  wr_data = '0;
    logic [CW-1:0] num_apps = '0;
    logic          start = 1'b0;
    logic          map_ready = 1'b1;
    logic          task_valid, root_task, app_end, busy, done;
    logic [W-1:0]  task_array;
    logic [AW-1:0] row, col;
    logic [CW-1:0] app_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_mat[16];
    logic [40:0] obs, expv;

    task_graph_streamer #(.NUM_V(NUM_V), .W(W), .HOLD_CYC(2), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .num_apps(num_apps), .start(start), .map_ready(map_ready),
        .task_valid(task_valid), .task_array(task_array), .row(row), .col(col),
        .root_task(root_task), .app_end(app_end), .busy(busy), .app_cnt(app_cnt),
        .done(done)
    );

    always #5 clk = ~clk;

    // bit layout: valid[40] row[39:38] col[37:36] weight[35:4] root[3] app_end[2] done[1] busy[0]
    assign obs = {task_valid, row, col, task_array, root_task, app_end, done, busy};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected outputs for a non-skipping stream of n applications, map_ready=1.
    function automatic logic [40:0] exp_std(input int rel, input int n);
        int p, k, fnz;
        logic v, rt, ae, dn, bz;
        logic [1:0] r, c;
        logic [31:0] w;
        v = 0; rt = 0; ae = 0; dn = 0; bz = 0; r = 0; c = 0; w = 0;
        fnz = -1;
        for (int i = 15; i >= 0; i--) if (exp_mat[i] != 0) fnz = i;
        if (rel >= 1 && rel <= 34 * n) begin
            bz = 1;
            p = (rel - 1) % 34;
            if (p < 32) begin
                k  = p / 2;
                v  = 1;
                r  = 2'(k / 4);
                c  = 2'(k % 4);
                w  = 32'(exp_mat[k]);
                rt = (k == fnz);
            end else if (p == 32) begin
                ae = 1;
            end else begin
                dn = (rel == 34 * n);
            end
        end
        return {v, r, c, w, rt, ae, dn, bz};
    endfunction

    // Pulse start; returns at the falling edge of the first cycle after the sampling edge.
    task automatic issue_start(input int n);
        num_apps = CW'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_matrix();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_row  = 2'(i / 4);
            wr_col  = 2'(i % 4);
            wr_data = 32'(exp_mat[i]);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (obs !== 41'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        n_checks++;
        if (app_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_app_cnt got=%0d exp=0", app_cnt); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== 41'd0) begin n_fail++; $display("FAIL post_reset_outputs got=%h exp=0", obs); end
    endtask

    task automatic test_single();
        issue_start(1);
        for (int rel = 1; rel <= 36; rel++) begin
            expv = exp_std(rel, 1);
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL single rel=%0d got=%h exp=%h", rel, obs, expv); end
            if (rel == 33) begin
                n_checks++;
                if (app_cnt !== 8'd0) begin n_fail++; $display("FAIL single_cnt_end got=%0d exp=0", app_cnt); end
            end
            if (rel == 34) begin
                n_checks++;
                if (app_cnt !== 8'd1) begin n_fail++; $display("FAIL single_cnt_done got=%0d exp=1", app_cnt); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_multi();
        issue_start(3);
        for (int rel = 1; rel <= 106; rel++) begin
            expv = exp_std(rel, 3);
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL multi rel=%0d got=%h exp=%h", rel, obs, expv); end
            if (rel == 34 || rel == 68 || rel == 102) begin
                n_checks++;
                if (app_cnt !== 8'(rel / 34)) begin
                    n_fail++; $display("FAIL multi_cnt rel=%0d got=%0d exp=%0d", rel, app_cnt, rel / 34);
                end
            end
            if (rel == 50 || rel == 102) begin
                num_apps = 8'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_stall();
        int k;
        logic v, rt, ae, dn, bz;
        logic [1:0] r, c;
        logic [31:0] w;
        issue_start(1);
        for (int rel = 1; rel <= 45; rel++) begin
            if (rel <= 4) k = (rel - 1) / 2;
            else if (rel <= 15) k = 2;
            else if (rel <= 41) k = 3 + (rel - 16) / 2;
            else k = -1;
            v = (k >= 0); r = 0; c = 0; w = 0; rt = 0;
            if (k >= 0) begin
                r = 2'(k / 4); c = 2'(k % 4); w = 32'(exp_mat[k]); rt = (k == 1);
            end
            ae = (rel == 42);
            dn = (rel == 43);
            bz = (rel <= 43);
            expv = {v, r, c, w, rt, ae, dn, bz};
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL stall rel=%0d got=%h exp=%h", rel, obs, expv); end
            map_ready = (rel >= 5 && rel <= 14) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        map_ready = 1'b1;
    endtask

    task automatic test_write_busy();
        issue_start(2);
        for (int rel = 1; rel <= 70; rel++) begin
            expv = exp_std(rel, 2);
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL wr_busy rel=%0d got=%h exp=%h", rel, obs, expv); end
            if (rel == 35) begin
                n_checks++;
                if (task_array !== 32'd0 || task_valid !== 1'b1) begin
                    n_fail++; $display("FAIL wr_busy_cell00 got=%0d valid=%b exp=0 valid=1", task_array, task_valid);
                end
            end
            if (rel == 10) begin
                wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'd9;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_zero_apps();
        issue_start(0);
        for (int rel = 1; rel <= 5; rel++) begin
            expv = 41'd0;
            if (rel == 1) expv[1] = 1'b1;
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL zero_apps rel=%0d got=%h exp=%h", rel, obs, expv); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        issue_start(1);
        for (int rel = 1; rel <= 10; rel++) begin
            expv = exp_std(rel, 1);
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL pre_rst rel=%0d got=%h exp=%h", rel, obs, expv); end
            if (rel < 10) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 41'd0) begin n_fail++; $display("FAIL rst_immediate got=%h exp=0", obs); end
        n_checks++;
        if (app_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_app_cnt got=%0d exp=0", app_cnt); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 41'd0) begin n_fail++; $display("FAIL rst_hold i=%0d got=%h exp=0", i, obs); end
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_mat[i] = 0;
        @(negedge clk);
        issue_start(1);
        for (int rel = 1; rel <= 36; rel++) begin
            expv = exp_std(rel, 1);
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL post_rst rel=%0d got=%h exp=%h", rel, obs, expv); end
            @(negedge clk);
        end
    endtask

    task automatic test_skip();
        int s, d, k, s_end;
        logic v, rt, ae, dn, bz;
        logic [1:0] r, c;
        logic [31:0] w;
        logic [40:0] mask;
        issue_start(1);
        for (int rel = 1; rel <= 26; rel++) begin
            s = 1; k = -1;
            for (int j = 0; j < 16; j++) begin
                d = (exp_mat[j] != 0) ? 2 : 1;
                if (rel >= s && rel < s + d) k = j;
                s = s + d;
            end
            s_end = s;
            v = 0; r = 0; c = 0; w = 0; rt = 0;
            if (k >= 0) begin
                v = (exp_mat[k] != 0); r = 2'(k / 4); c = 2'(k % 4);
                w = 32'(exp_mat[k]); rt = (k == 1);
            end
            ae = (rel == s_end);
            dn = (rel == s_end + 1);
            bz = (rel <= s_end + 1);
            expv = {v, r, c, w, rt, ae, dn, bz};
            mask = '1;
            if (!v) mask[35:4] = '0;
            n_checks++;
            if ((obs & mask) !== (expv & mask)) begin
                n_fail++; $display("FAIL skip rel=%0d got=%h exp=%h", rel, obs & mask, expv & mask);
            end
            @(negedge clk);
        end
        n_checks++;
        if (s_end !== 23) begin n_fail++; $display("FAIL skip_app_end_cycle got=%0d exp=23", s_end); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_mat[i] = 0;
        exp_mat[1] = 5;  exp_mat[4] = 5;
        exp_mat[6] = 6;  exp_mat[9] = 6;
        exp_mat[3] = 7;  exp_mat[12] = 7;
        test_reset();
        load_matrix();
`ifdef SKIP_ZERO_EN
        test_skip();
`else
        test_single();
        test_multi();
        test_stall();
        test_write_busy();
        test_zero_apps();
        test_reset_midrun();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
